// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: bus widths,
// access-controller state encodings, EXE_to_MEM field positions and the
// byte-enable helper used for both store strobes and the WB bus.
package mem_access_stage_pkg;

    localparam int EXE_TO_MEM_BUS_WD = 105;
    localparam int MEM_TO_WB_BUS_WD  = 108;
    localparam int MEM_TO_ID_BUS_WD  = 38;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT,
        S_DONE = ST_DONE
    } mem_state_e;

    // EXE_to_MEM_bus field positions (LSB of each field)
    localparam int E_RF_W_EN     = 104;
    localparam int E_IS_LOAD     = 103;
    localparam int E_IS_STORE    = 102;
    localparam int E_BYTE_OP     = 101;
    localparam int E_RF_W_ADDR   = 96;
    localparam int E_ALU_RESULT  = 64;
    localparam int E_STORE_DATA  = 32;
    localparam int E_INST_PC     = 0;

    // Byte accesses select one lane from the low address bits; word
    // accesses always use all four lanes.
    function automatic logic [3:0] calc_b_en(input logic byte_op, input logic [1:0] offset);
        return byte_op ? (4'b0001 << offset) : 4'b1111;
    endfunction

endpackage

// File: rtl/mem_access_stage_req_ctrl.sv
// mem_req_ctrl: data-RAM access controller for the memory stage.
// Owns the IDLE/REQ/WAIT/DONE state, the request line and the load-data
// register. The instruction's stage exit is signalled in via 'leave'.
// Handshake: data_ram_req stays high with stable fields until gnt; a load's
// rdata is taken on the first rvalid seen in WAIT (earliest the cycle after
// gnt); gnt outside a request and rvalid outside WAIT are ignored.
module mem_req_ctrl
    import mem_access_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        leave,
    input  logic        gnt,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    output logic        req,
    output logic        access_done,
    output logic [31:0] r_data,
    output mem_state_e  state
);

    logic        mem_op;
    logic [31:0] r_data_q;

    // Request, completion and read-data view derived from the current state
    always_comb begin
        mem_op      = valid & (is_load | is_store);
        req         = mem_op & ((state == S_IDLE) | (state == S_REQ));
        access_done = (req & gnt & is_store) | ((state == S_WAIT) & rvalid);
        r_data      = 32'b0;
        if (is_load) begin
            // Pass the response straight through in its arrival cycle so a
            // load with an open WB slot costs no extra cycle.
            r_data = (state == S_WAIT) ? rdata : r_data_q;
        end
    end

    // Access FSM and load-data register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            r_data_q <= 32'b0;
        end else begin
            if ((state == S_WAIT) && rvalid) begin
                r_data_q <= rdata;
            end
            if (leave) begin
                // A newly accepted memory op re-requests straight from IDLE.
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_REQ: begin
                        if (mem_op) begin
                            if (gnt) begin
                                state <= is_store ? S_DONE : S_WAIT;
                            end else begin
                                state <= S_REQ;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (rvalid) begin
                            state <= S_DONE;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline stage ahead of write-back. Holds one
// instruction from EXE, performs its data-RAM access through mem_req_ctrl
// and presents the MEM_to_WB bus.
// Pipeline handshake: a bus moves when its valid and the receiver's
// allow_in are both high at a rising clock edge.
// Optional: define MEM_FWD_EN to build the MEM_to_ID forwarding port.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
    input  logic                         EXE_to_MEM_valid,
    output logic                         MEM_allow_in,
    output logic [MEM_TO_WB_BUS_WD-1:0]  MEM_to_WB_bus,
    output logic                         MEM_to_WB_valid,
    input  logic                         WB_allow_in,
    output logic                         data_ram_req,
    output logic                         data_ram_we,
    output logic [3:0]                   data_ram_wstrb,
    output logic [31:0]                  data_ram_addr,
    output logic [31:0]                  data_ram_wdata,
    input  logic                         data_ram_gnt,
    input  logic                         data_ram_rvalid,
    input  logic [31:0]                  data_ram_rdata
`ifdef MEM_FWD_EN
    ,
    output logic [MEM_TO_ID_BUS_WD-1:0]  MEM_to_ID_bus
`endif
);

    logic                         mem_valid;
    logic [EXE_TO_MEM_BUS_WD-1:0] bus_q;
    logic                         rf_w_en;
    logic                         is_load;
    logic                         is_store;
    logic                         byte_op;
    logic [4:0]                   rf_w_addr;
    logic [31:0]                  alu_result;
    logic [31:0]                  store_data;
    logic [31:0]                  inst_pc;
    logic [3:0]                   b_en;
    logic                         ready_go;
    logic                         leave;
    logic                         access_done;
    logic                         req;
    logic [31:0]                  r_data;
    mem_state_e                   ctrl_state;

    assign rf_w_en    = bus_q[E_RF_W_EN];
    assign is_load    = bus_q[E_IS_LOAD];
    assign is_store   = bus_q[E_IS_STORE];
    assign byte_op    = bus_q[E_BYTE_OP];
    assign rf_w_addr  = bus_q[E_RF_W_ADDR +: 5];
    assign alu_result = bus_q[E_ALU_RESULT +: 32];
    assign store_data = bus_q[E_STORE_DATA +: 32];
    assign inst_pc    = bus_q[E_INST_PC +: 32];

    // Stage handshake: non-memory ops are ready at once, memory ops once
    // their access completes (this cycle or an earlier one).
    always_comb begin
        ready_go        = ~(is_load | is_store) | (ctrl_state == S_DONE) | access_done;
        MEM_to_WB_valid = mem_valid & ready_go;
        MEM_allow_in    = ~mem_valid | (ready_go & WB_allow_in);
        leave           = mem_valid & ready_go & WB_allow_in;
    end

    // Stage register: valid follows upstream whenever the slot opens
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid <= 1'b0;
            bus_q     <= '0;
        end else if (MEM_allow_in) begin
            mem_valid <= EXE_to_MEM_valid;
            if (EXE_to_MEM_valid) begin
                bus_q <= EXE_to_MEM_bus;
            end
        end
    end

    mem_req_ctrl u_req_ctrl (
        .clk         (clk),
        .reset       (reset),
        .valid       (mem_valid),
        .is_load     (is_load),
        .is_store    (is_store),
        .leave       (leave),
        .gnt         (data_ram_gnt),
        .rvalid      (data_ram_rvalid),
        .rdata       (data_ram_rdata),
        .req         (req),
        .access_done (access_done),
        .r_data      (r_data),
        .state       (ctrl_state)
    );

    // RAM request fields and WB bus packing
    always_comb begin
        b_en           = calc_b_en(byte_op, alu_result[1:0]);
        data_ram_req   = req;
        data_ram_we    = is_store;
        data_ram_wstrb = is_store ? b_en : 4'b0000;
        data_ram_addr  = {alu_result[31:2], 2'b00};
        data_ram_wdata = byte_op ? {4{store_data[7:0]}} : store_data;
        MEM_to_WB_bus  = {rf_w_en, is_load, byte_op, b_en, r_data,
                          rf_w_addr, alu_result, inst_pc};
    end

`ifdef MEM_FWD_EN
    // Loads are excluded: their result is not known until write-back.
    always_comb begin
        MEM_to_ID_bus = {mem_valid & rf_w_en & ~is_load, rf_w_addr, alu_result};
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: random instruction stream, random
// WB back-pressure and a randomly delaying data RAM. A transaction-level
// model predicts per-cycle valid/allow_in/req and the WB bus contents.
module tb_mem_access_stage;

    typedef struct packed {
        logic        rf_w_en;
        logic        is_load;
        logic        is_store;
        logic        byte_op;
        logic [4:0]  rf_w_addr;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] pc;
    } instr_t;

    logic          clk;
    logic          reset;
    logic [104:0]  EXE_to_MEM_bus;
    logic          EXE_to_MEM_valid;
    logic          MEM_allow_in;
    logic [107:0]  MEM_to_WB_bus;
    logic          MEM_to_WB_valid;
    logic          WB_allow_in;
    logic          data_ram_req;
    logic          data_ram_we;
    logic [3:0]    data_ram_wstrb;
    logic [31:0]   data_ram_addr;
    logic [31:0]   data_ram_wdata;
    logic          data_ram_gnt;
    logic          data_ram_rvalid;
    logic [31:0]   data_ram_rdata;
`ifdef MEM_FWD_EN
    logic [37:0]   MEM_to_ID_bus;
`endif

    mem_access_stage dut (
        .clk              (clk),
        .reset            (reset),
        .EXE_to_MEM_bus   (EXE_to_MEM_bus),
        .EXE_to_MEM_valid (EXE_to_MEM_valid),
        .MEM_allow_in     (MEM_allow_in),
        .MEM_to_WB_bus    (MEM_to_WB_bus),
        .MEM_to_WB_valid  (MEM_to_WB_valid),
        .WB_allow_in      (WB_allow_in),
        .data_ram_req     (data_ram_req),
        .data_ram_we      (data_ram_we),
        .data_ram_wstrb   (data_ram_wstrb),
        .data_ram_addr    (data_ram_addr),
        .data_ram_wdata   (data_ram_wdata),
        .data_ram_gnt     (data_ram_gnt),
        .data_ram_rvalid  (data_ram_rvalid),
        .data_ram_rdata   (data_ram_rdata)
`ifdef MEM_FWD_EN
        ,
        .MEM_to_ID_bus    (MEM_to_ID_bus)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            checks;
    int            errors;
    logic [107:0]  exp_q[$];
    logic [31:0]   ram_mem[logic [31:0]];   // what the RAM really holds
    logic [31:0]   ref_mem[logic [31:0]];   // program-order reference

    bit            in_stage;
    instr_t        cur;
    bit            granted;
    bit            done;
    bit            exe_hold;
    bit            gen_en;
    bit            pend;
    int            pend_dly;
    logic [31:0]   pend_data;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [3:0] exp_ben(input logic byte_op, input logic [1:0] off);
        if (!byte_op) return 4'hF;
        case (off)
            2'd0: return 4'h1;
            2'd1: return 4'h2;
            2'd2: return 4'h4;
            default: return 4'h8;
        endcase
    endfunction

    function automatic instr_t gen_instr();
        instr_t i;
        int kind;
        kind        = $urandom_range(0, 2);
        i.is_load   = (kind == 1);
        i.is_store  = (kind == 2);
        i.byte_op   = 1'($urandom_range(0, 1));
        i.rf_w_en   = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind == 1);
        i.rf_w_addr = 5'($urandom_range(0, 31));
        i.alu       = (kind == 0) ? 32'($urandom)
                                  : 32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
        i.sdata     = 32'($urandom);
        i.pc        = 32'($urandom) & 32'hFFFF_FFFC;
        return i;
    endfunction

    // Model: instruction enters the stage; predict its WB bus now, in
    // program order, and apply a store to the reference memory.
    task automatic model_accept(input instr_t i);
        logic [3:0]  be;
        logic [31:0] wa;
        logic [31:0] w;
        logic [31:0] rd;
        be = exp_ben(i.byte_op, i.alu[1:0]);
        wa = {i.alu[31:2], 2'b00};
        rd = i.is_load ? ref_rd(wa) : 32'h0;
        exp_q.push_back({i.rf_w_en, i.is_load, i.byte_op, be, rd, i.rf_w_addr, i.alu, i.pc});
        if (i.is_store) begin
            w = ref_rd(wa);
            for (int b = 0; b < 4; b++) begin
                if (be[b]) w[8*b +: 8] = i.byte_op ? i.sdata[7:0] : i.sdata[8*b +: 8];
            end
            ref_mem[wa] = w;
        end
        in_stage = 1;
        cur      = i;
        granted  = 0;
        done     = 0;
    endtask

    // One clock cycle of random driving, checking and model update
    task automatic step();
        bit          exp_req;
        bit          grant_now;
        bit          resp_now;
        bit          load_resp;
        bit          exp_rdy;
        bit          exp_allow;
        bit          cur_mem;
        logic [31:0] w;
        @(negedge clk);
        if (!exe_hold) begin
            if (gen_en && $urandom_range(0, 3) != 0) begin
                EXE_to_MEM_valid = 1'b1;
                EXE_to_MEM_bus   = gen_instr();
            end else begin
                EXE_to_MEM_valid = 1'b0;
            end
        end
        WB_allow_in  = ($urandom_range(0, 3) != 0);
        data_ram_gnt = 1'($urandom_range(0, 1));
        if (pend) begin
            if (pend_dly == 0) begin
                data_ram_rvalid = 1'b1;
                data_ram_rdata  = pend_data;
            end else begin
                data_ram_rvalid = 1'b0;
                data_ram_rdata  = 32'($urandom);
                pend_dly--;
            end
        end else begin
            data_ram_rvalid = ($urandom_range(0, 3) == 0);
            data_ram_rdata  = 32'($urandom);
        end
        #1;
        cur_mem   = in_stage && (cur.is_load || cur.is_store);
        resp_now  = pend && data_ram_rvalid;
        exp_req   = cur_mem && !granted;
        check("req", data_ram_req, exp_req);
        if (exp_req) begin
            check("addr", data_ram_addr, {cur.alu[31:2], 2'b00});
            check("we", data_ram_we, cur.is_store);
            check("wstrb", data_ram_wstrb, cur.is_store ? exp_ben(cur.byte_op, cur.alu[1:0]) : 4'h0);
            if (cur.is_store)
                check("wdata", data_ram_wdata, cur.byte_op ? {4{cur.sdata[7:0]}} : cur.sdata);
        end
        check("one_outstanding", data_ram_req && pend, 1'b0);
        grant_now = exp_req && data_ram_gnt;
        load_resp = cur_mem && cur.is_load && granted && !done && resp_now;
        exp_rdy   = in_stage && (!cur_mem || done || (cur.is_store && grant_now) || load_resp);
        check("wb_valid", MEM_to_WB_valid, exp_rdy);
        exp_allow = !in_stage || (exp_rdy && WB_allow_in);
        check("allow_in", MEM_allow_in, exp_allow);
        if (exp_rdy) check("wb_bus", MEM_to_WB_bus, exp_q[0]);

        // RAM side reacts to what the DUT actually did
        if (resp_now) pend = 0;
        if (data_ram_req && data_ram_gnt && !pend) begin
            if (data_ram_we) begin
                w = ram_rd(data_ram_addr);
                for (int b = 0; b < 4; b++) begin
                    if (data_ram_wstrb[b]) w[8*b +: 8] = data_ram_wdata[8*b +: 8];
                end
                ram_mem[data_ram_addr] = w;
            end else begin
                pend      = 1;
                pend_data = ram_rd(data_ram_addr);
                pend_dly  = $urandom_range(0, 2);
            end
        end

        // Model advances
        if (grant_now) granted = 1;
        if ((cur.is_store && grant_now) || load_resp) done = 1;
        if (exp_rdy && WB_allow_in) begin
            void'(exp_q.pop_front());
            in_stage = 0;
        end
        if (EXE_to_MEM_valid && exp_allow) begin
            model_accept(instr_t'(EXE_to_MEM_bus));
            exe_hold = 0;
        end else begin
            exe_hold = EXE_to_MEM_valid;
        end
    endtask

    task automatic clear_model();
        in_stage = 0;
        granted  = 0;
        done     = 0;
        exe_hold = 0;
        pend     = 0;
        pend_dly = 0;
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        instr_t ld;
        bit     drained;
        checks = 0;
        errors = 0;
        clear_model();
        reset            = 1'b0;
        EXE_to_MEM_valid = 1'b0;
        EXE_to_MEM_bus   = '0;
        WB_allow_in      = 1'b0;
        data_ram_gnt     = 1'b0;
        data_ram_rvalid  = 1'b0;
        data_ram_rdata   = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_allow_in", MEM_allow_in, 1'b1);
        check("rst_wb_valid", MEM_to_WB_valid, 1'b0);
        check("rst_req", data_ram_req, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Random traffic
        gen_en = 1;
        repeat (1500) step();

        // Drain the stage
        gen_en  = 0;
        drained = 0;
        for (int n = 0; n < 80 && !drained; n++) begin
            step();
            drained = !in_stage && !pend && !exe_hold;
        end
        check("drain_timeout", drained, 1'b1);

        // Reset while a load waits for its response
        ld = '0;
        ld.is_load   = 1'b1;
        ld.rf_w_en   = 1'b1;
        ld.rf_w_addr = 5'd9;
        ld.alu       = 32'h140;
        ld.pc        = 32'h8000_0040;
        @(negedge clk);
        EXE_to_MEM_valid = 1'b1;
        EXE_to_MEM_bus   = ld;
        WB_allow_in      = 1'b1;
        data_ram_gnt     = 1'b0;
        data_ram_rvalid  = 1'b0;
        #1;
        check("wr_allow_in", MEM_allow_in, 1'b1);
        @(negedge clk);
        EXE_to_MEM_valid = 1'b0;
        data_ram_gnt     = 1'b1;
        #1;
        check("wr_req", data_ram_req, 1'b1);
        check("wr_req_addr", data_ram_addr, 32'h140);
        @(negedge clk);
        data_ram_gnt = 1'b0;
        #1;
        check("wait_req_low", data_ram_req, 1'b0);
        check("wait_wb_valid", MEM_to_WB_valid, 1'b0);
        check("wait_allow_in", MEM_allow_in, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_req", data_ram_req, 1'b0);
        check("async_rst_wb_valid", MEM_to_WB_valid, 1'b0);
        check("async_rst_allow_in", MEM_allow_in, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        data_ram_rvalid = 1'b1;
        data_ram_rdata  = 32'hCAFE_F00D;
        #1;
        check("stale_rvalid_wb_valid", MEM_to_WB_valid, 1'b0);
        check("stale_rvalid_req", data_ram_req, 1'b0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            data_ram_rvalid = 1'b0;
            #1;
            check("post_rst_wb_valid", MEM_to_WB_valid, 1'b0);
            check("post_rst_allow_in", MEM_allow_in, 1'b1);
        end

        // Recovery: random traffic again from a clean model
        clear_model();
        gen_en = 1;
        repeat (300) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline stage preceding write-back. Latches the EXE_to_MEM bus, performs the data-RAM access for loads and stores over a request/grant/response handshake, and drives the MEM_to_WB bus with the raw read word, byte enables and ALU result that write-back consumes. Uses the valid/allow_in pipeline handshake, so RAM wait states stall upstream stages cleanly.

## Interface
- No parameters; widths come from shared header macros: `EXE_TO_MEM_BUS_WD` = 105, `MEM_TO_WB_BUS_WD` = 108, `MEM_TO_ID_BUS_WD` = 38.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (0 = reset); the only clock is clk
- EXE_to_MEM_bus  input  105  {rf_w_en, is_load, is_store, byte_op, rf_w_addr[4:0], alu_result[31:0], store_data[31:0], inst_PC[31:0]}
- EXE_to_MEM_valid  input  1  upstream holds a valid instruction
- MEM_allow_in  output  1  stage accepts a new instruction this cycle
- MEM_to_WB_bus  output  108  {rf_w_en, sel_rf_w_data(=is_load), byte_op, b_en[3:0], r_data[31:0], rf_w_addr[4:0], alu_result[31:0], inst_PC[31:0]}
- MEM_to_WB_valid  output  1  bus content valid for WB
- WB_allow_in  input  1  WB accepts
- data_ram_req  output  1  access request
- data_ram_we  output  1  1 = store
- data_ram_wstrb  output  4  byte write strobes
- data_ram_addr  output  32  word-aligned address {alu_result[31:2], 2'b00}
- data_ram_wdata  output  32  store data
- data_ram_gnt  input  1  request accepted this cycle
- data_ram_rvalid  input  1  read data valid
- data_ram_rdata  input  32  read data
- MEM_to_ID_bus  output  38  forwarding bus; present only with `MEM_FWD_EN`

## Operation
- Stage register loads EXE_to_MEM_bus when EXE_to_MEM_valid & MEM_allow_in; MEM_valid <= EXE_to_MEM_valid when MEM_allow_in.
- MEM_allow_in = ~MEM_valid | (MEM_ready_go & WB_allow_in); MEM_to_WB_valid = MEM_valid & MEM_ready_go.
- b_en: byte_op ? (4'b0001 << alu_result[1:0]) : 4'b1111. Word accesses ignore alu_result[1:0].
- Store: wstrb = b_en; wdata = byte_op ? {4{store_data[7:0]}} : store_data. Load: wstrb = 4'b0000, we = 0.
- FSM: IDLE, REQ, WAIT, DONE.
  - IDLE: entry state for every accepted instruction. Non-memory instruction: ready_go = 1, stays IDLE. Memory instruction: req asserted combinationally, acts as REQ.
  - REQ: req = 1 with stable addr/we/wstrb/wdata until gnt. On gnt: store -> DONE; load -> WAIT.
  - WAIT: req = 0; on rvalid capture rdata into r_data register -> DONE.
  - DONE: ready_go = 1; r_data held stable; on WB_allow_in -> IDLE (or directly into REQ if the newly accepted instruction is a memory op).
- r_data = 32'b0 for non-load instructions.
- rvalid in IDLE/REQ/DONE is ignored; gnt outside REQ is ignored.

## Timing
- Reset (asynchronous, active-low): MEM_valid = 0, FSM = IDLE, data_ram_req = 0, r_data = 0, MEM_to_WB_valid = 0, MEM_allow_in = 1; other outputs are don't-care. A response arriving after reset release for a pre-reset request is dropped because the FSM is not in WAIT.
- Non-memory op: 1 cycle in stage.
- Store with gnt in the request cycle: 1 cycle. Each gnt delay cycle adds 1 cycle.
- Load with gnt in the request cycle and rvalid next cycle: 2 cycles. rvalid arrives at earliest the cycle after gnt.
- WB_allow_in = 0 in DONE: all MEM_to_WB_bus fields are frozen and no new RAM request is issued.
- At most one outstanding RAM request at any time.

## Configuration
- `MEM_FWD_EN` defined: MEM_to_ID_bus = {MEM_valid & rf_w_en & ~is_load, rf_w_addr, alu_result}, so ID can bypass ALU results from this stage.
- `MEM_FWD_EN` undefined: port absent and no forwarding logic is built.

## Structure
- Shared header holds the bus width macros, the FSM state encodings (2-bit localparams), and the bus field bit positions.
- One natural sub-module, `mem_req_ctrl`: owns the FSM, req/gnt/rvalid handling and the r_data register. The top level owns the stage register, the handshake and the bus packing.

## Test plan
- ALU op (add result 0x1234, rf_w_addr 5) with WB_allow_in = 1 -> MEM_to_WB_valid next cycle, no req, alu_result = 0x1234.
- Word load at 0x100, gnt immediate, rvalid 1 cycle later with 0xDEADBEEF -> b_en = 1111, r_data = 0xDEADBEEF, valid 2 cycles after accept.
- Byte store at 0x103 with data 0x5A, gnt delayed 3 cycles -> req held 4 cycles, wstrb = 1000, wdata = 0x5A5A5A5A, addr = 0x100, MEM_allow_in low until gnt.
- Load completes while WB_allow_in = 0 for 2 cycles -> bus and r_data stable, no new req, upstream stalled.
- Reset asserted in WAIT, then rvalid arrives after release -> req drops immediately, response ignored, MEM_to_WB_valid stays 0.
- Back-to-back load/load -> second req issued the cycle the first leaves DONE, no bubble beyond RAM latency.
